// File: rtl/net_seq_pkg.sv
// Shared types and constants for the net_seq sample scheduler.
package net_seq_pkg;

  localparam int unsigned WordDataBus  = 32;
  localparam int unsigned NSEQ_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    NSEQ_IDLE = 3'd0,
    NSEQ_LOAD = 3'd1,
    NSEQ_CLR  = 3'd2,
    NSEQ_FIRE = 3'd3,
    NSEQ_WAIT = 3'd4,
    NSEQ_OUT  = 3'd5,
    NSEQ_DONE = 3'd6
  } nseq_state_e;

  // net is held cleared everywhere except while it computes and its result is consumed.
  function automatic logic nseq_net_reset(input nseq_state_e s);
    return !(s inside {NSEQ_FIRE, NSEQ_WAIT, NSEQ_OUT});
  endfunction

endpackage

// File: rtl/net_seq_loader.sv
// RAM read sequencer and holding-register bank: issues N_IN sequential reads while
// load_en is high and captures each word one cycle after its read.
module net_seq_loader
  import net_seq_pkg::*;
#(
  parameter int unsigned WORD_W = WordDataBus,
  parameter int unsigned N_IN   = 7,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     addr_set,
  input  logic [ADDR_W-1:0]        addr_init,
  input  logic                     load_en,
  output logic                     load_done,
  output logic                     ram_rd,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [WORD_W-1:0]        ram_data,
  output logic [N_IN*WORD_W-1:0]   data_out
);

  localparam int unsigned CntW = $clog2(N_IN + 1);

  logic [CntW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   cap_vld_q, cap_vld_d;
  logic [CntW-1:0]        cap_idx_q, cap_idx_d;
  logic [N_IN*WORD_W-1:0] hold_q, hold_d;
  logic                   rd;

  always_comb begin
    rd        = load_en && (rd_cnt_q < CntW'(N_IN));
    rd_cnt_d  = rd_cnt_q;
    if (!load_en) begin
      rd_cnt_d = '0;
    end else if (rd) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    // Address runs on across samples so sample i starts at base + i*N_IN.
    addr_d = addr_q;
    if (addr_set) begin
      addr_d = addr_init;
    end else if (rd) begin
      addr_d = addr_q + 1'b1;
    end
    cap_vld_d = rd;
    cap_idx_d = rd_cnt_q;
    hold_d    = hold_q;
    for (int k = 0; k < N_IN; k++) begin
      if (cap_vld_q && (cap_idx_q == CntW'(k))) begin
        hold_d[k*WORD_W +: WORD_W] = ram_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q  <= '0;
      addr_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      hold_q    <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      addr_q    <= addr_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      hold_q    <= hold_d;
    end
  end

  assign load_done = cap_vld_q && (cap_idx_q == CntW'(N_IN - 1));
  assign ram_rd    = rd;
  assign ram_addr  = addr_q;
  assign data_out  = hold_q;

endmodule

// File: rtl/net_seq.sv
// Sample scheduler for the MLP net datapath: load inputs, clear, fire, collect, hand off.
// Optional watchdog on the net result is enabled by defining NET_TIMEOUT_EN.
module net_seq
  import net_seq_pkg::*;
#(
  parameter int unsigned WORD_W  = WordDataBus,
  parameter int unsigned N_IN    = 7,
  parameter int unsigned N_OUT   = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CLR_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [IDX_W-1:0]         n_samples,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_rd,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [WORD_W-1:0]        ram_data,
  output logic                     net_reset,
  output logic                     net_in_rdy,
  output logic [N_IN*WORD_W-1:0]   net_data_in,
  input  logic [N_OUT*WORD_W-1:0]  net_out,
  input  logic                     net_rdy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_OUT*WORD_W-1:0]  res_data,
  output logic [IDX_W-1:0]         res_idx,
  output logic                     err
);

  localparam int unsigned ClrW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  nseq_state_e              state_q, state_d;
  logic [IDX_W-1:0]         n_q, n_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         idx_inc;
  logic [ClrW-1:0]          clr_cnt_q, clr_cnt_d;
  logic [N_OUT*WORD_W-1:0]  res_data_q, res_data_d;
  logic [IDX_W-1:0]         res_idx_q, res_idx_d;
  logic                     addr_set;
  logic                     load_done;
  logic                     timeout;

  net_seq_loader #(
    .WORD_W (WORD_W),
    .N_IN   (N_IN),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .addr_set  (addr_set),
    .addr_init (base_addr),
    .load_en   (state_q == NSEQ_LOAD),
    .load_done (load_done),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .data_out  (net_data_in)
  );

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    clr_cnt_d  = '0;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    addr_set   = 1'b0;
    unique case (state_q)
      NSEQ_IDLE: begin
        if (start) begin
          n_d      = n_samples;
          idx_d    = '0;
          addr_set = 1'b1;
          state_d  = (n_samples == '0) ? NSEQ_DONE : NSEQ_LOAD;
        end
      end
      NSEQ_LOAD: begin
        if (load_done) state_d = NSEQ_CLR;
      end
      NSEQ_CLR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ClrW'(CLR_CYC - 1)) state_d = NSEQ_FIRE;
      end
      NSEQ_FIRE: state_d = NSEQ_WAIT;
      NSEQ_WAIT: begin
        if (net_rdy) begin
          res_data_d = net_out;
          res_idx_d  = idx_q;
          state_d    = NSEQ_OUT;
        end else if (timeout) begin
          // Abandoned sample: advance exactly as after a completed handshake.
          idx_d   = idx_inc;
          state_d = (idx_inc == n_q) ? NSEQ_DONE : NSEQ_LOAD;
        end
      end
      NSEQ_OUT: begin
        if (res_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == n_q) ? NSEQ_DONE : NSEQ_LOAD;
        end
      end
      NSEQ_DONE: state_d = NSEQ_IDLE;
      default:   state_d = NSEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= NSEQ_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      clr_cnt_q  <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      clr_cnt_q  <= clr_cnt_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

`ifdef NET_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  // Counter is zero on every WAIT entry because it is held clear outside WAIT.
  assign timeout = (state_q == NSEQ_WAIT) && !net_rdy &&
                   (wdog_q == 16'(NSEQ_TIMEOUT - 1));

  always_comb begin
    wdog_d = '0;
    if ((state_q == NSEQ_WAIT) && !net_rdy) wdog_d = wdog_q + 16'd1;
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy       = (state_q != NSEQ_IDLE);
  assign done       = (state_q == NSEQ_DONE);
  assign net_reset  = nseq_net_reset(state_q);
  assign net_in_rdy = (state_q == NSEQ_FIRE);
  assign res_valid  = (state_q == NSEQ_OUT);
  assign res_data   = res_data_q;
  assign res_idx    = res_idx_q;

endmodule

// File: tb/tb_net_seq.sv
// Directed bench for net_seq with a RAM model and a fixed-latency net model.
module tb_net_seq;
  import net_seq_pkg::*;

  localparam int unsigned WORD_W  = WordDataBus;
  localparam int unsigned N_IN    = 7;
  localparam int unsigned N_OUT   = 2;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned CLR_CYC = 2;
  localparam int unsigned DW      = N_IN * WORD_W;
  localparam int unsigned RW      = N_OUT * WORD_W;
  localparam int          NET_LAT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  n_samples = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              res_ready = 1'b1;
  logic [WORD_W-1:0] ram_data = '0;
  logic              busy, done, ram_rd, net_reset, net_in_rdy, net_rdy, res_valid, err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DW-1:0]     net_data_in;
  logic [RW-1:0]     net_out, res_data;
  logic [IDX_W-1:0]  res_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  net_seq #(
    .WORD_W (WORD_W), .N_IN (N_IN), .N_OUT (N_OUT),
    .ADDR_W (ADDR_W), .IDX_W (IDX_W), .CLR_CYC (CLR_CYC)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .n_samples (n_samples),
    .base_addr (base_addr), .busy (busy), .done (done), .ram_rd (ram_rd),
    .ram_addr (ram_addr), .ram_data (ram_data), .net_reset (net_reset),
    .net_in_rdy (net_in_rdy), .net_data_in (net_data_in), .net_out (net_out),
    .net_rdy (net_rdy), .res_valid (res_valid), .res_ready (res_ready),
    .res_data (res_data), .res_idx (res_idx), .err (err)
  );

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  // net model: result NET_LAT cycles after fire, unless this fire is the one to drop.
  int            skip_fire = -1;
  int            nfire = 0;
  bit            net_fixed = 1'b0;
  logic          model_rdy = 1'b0;
  logic          spur_rdy = 1'b0;
  logic          silent = 1'b0;
  int            lat_cnt = 0;
  logic [RW-1:0] model_out = '0;

  assign net_rdy = model_rdy | spur_rdy;
  assign net_out = model_out;

  function automatic logic [WORD_W-1:0] word_sum(input logic [DW-1:0] d);
    logic [WORD_W-1:0] s = '0;
    for (int k = 0; k < N_IN; k++) s = s + d[k*WORD_W +: WORD_W];
    return s;
  endfunction

  always @(posedge clk) begin
    if (net_reset) begin
      model_rdy <= 1'b0;
      lat_cnt   <= 0;
    end else if (net_in_rdy) begin
      lat_cnt   <= NET_LAT - 1;
      silent    <= (skip_fire == nfire - 1);
      model_out <= net_fixed ? {32'h0000_000B, 32'h0000_000A}
                             : {net_data_in[WORD_W-1:0] ^ 32'hFFFF_0000, word_sum(net_data_in)};
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !silent) model_rdy <= 1'b1;
    end
  end

  // Sample i of a job holds words 7i+1..7i+7 (see fill_ram).
  function automatic logic [RW-1:0] exp_res(input int i);
    return {32'(7 * i + 1) ^ 32'hFFFF_0000, 32'(49 * i + 28)};
  endfunction

  task automatic fill_ram(input int base, input int count);
    for (int j = 0; j < count; j++) mem[ADDR_W'(base + j)] = 32'(j + 1);
  endtask

  logic [IDX_W-1:0]  got_idx[$];
  logic [RW-1:0]     got_data[$];
  logic [ADDR_W-1:0] rd_addr[$];
  logic [DW-1:0]     fire_data[$];
  int ndone, first_fire_k, first_valid_k, done_k, unstable;
  bit timed_out;

  // Runs one job and records what the DUT did; comparisons live in the test tasks.
  task automatic run_job(input int n, input int base, input int stall, input bit spur,
                         input bit restart, input int abort_fire, input int max_cyc);
    logic [RW-1:0]    held_data;
    logic [IDX_W-1:0] held_idx;
    int  wait_cnt = 0;
    bit  finished = 1'b0;
    got_idx.delete(); got_data.delete(); rd_addr.delete(); fire_data.delete();
    nfire = 0; ndone = 0; first_fire_k = -1; first_valid_k = -1; done_k = -1;
    unstable = 0; timed_out = 1'b0; held_data = '0; held_idx = '0;
    @(negedge clk);
    start = 1'b1; n_samples = IDX_W'(n); base_addr = ADDR_W'(base);
    res_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (k > 1) @(negedge clk);
      if (ram_rd) rd_addr.push_back(ram_addr);
      if (net_in_rdy) begin
        nfire++;
        fire_data.push_back(net_data_in);
        if (first_fire_k < 0) first_fire_k = k;
      end
      if (done) begin ndone++; done_k = k; end
      if (res_valid) begin
        if (first_valid_k < 0) first_valid_k = k;
        if (wait_cnt > 0 && (res_data !== held_data || res_idx !== held_idx)) unstable++;
        if (wait_cnt < stall) begin
          res_ready = 1'b0; wait_cnt++; held_data = res_data; held_idx = res_idx;
        end else begin
          res_ready = 1'b1; wait_cnt = 0;
          got_idx.push_back(res_idx); got_data.push_back(res_data);
        end
      end else if (stall > 0) begin
        res_ready = 1'b0;
      end
      spur_rdy = spur && ram_rd;
      start = restart && (k == 3);
      if (restart && k == 3) begin n_samples = 8'd9; base_addr = 10'h300; end
      if (abort_fire > 0 && nfire == abort_fire && !net_in_rdy) begin
        #2 reset = 1'b0;
        finished = 1'b1;
        break;
      end
      if (ndone > 0 && !busy) begin finished = 1'b1; break; end
    end
    spur_rdy = 1'b0; start = 1'b0; res_ready = 1'b1;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_tests++; if ({busy, done, ram_rd, net_in_rdy, res_valid, err} !== 6'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, ram_rd, net_in_rdy, res_valid, err}); end
    n_tests++; if (net_reset !== 1'b1) begin n_fail++;
      $display("FAIL reset_net_reset: got %b expected 1", net_reset); end
    n_tests++; if (ram_addr !== '0 || res_idx !== '0) begin n_fail++;
      $display("FAIL reset_addr_idx: got %h/%h expected 0/0", ram_addr, res_idx); end
    n_tests++; if (net_data_in !== '0 || res_data !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h/%h expected 0/0", net_data_in, res_data); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_in;
    logic [DW-1:0] got_in;
    for (int k = 0; k < N_IN; k++) exp_in[k*WORD_W +: WORD_W] = 32'(k + 1);
    fill_ram('h010, 7);
    net_fixed = 1'b1;
    run_job(1, 'h010, 0, 1'b0, 1'b0, 0, 100);
    got_in = (fire_data.size() > 0) ? fire_data[0] : '0;
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: job did not finish"); end
    n_tests++; if (nfire != 1) begin n_fail++; $display("FAIL single_fires: got %0d expected 1", nfire); end
    n_tests++; if (got_in !== exp_in) begin n_fail++; $display("FAIL single_net_data_in: got %h expected %h", got_in, exp_in); end
    n_tests++; if (got_idx.size() != 1) begin n_fail++; $display("FAIL single_nres: got %0d expected 1", got_idx.size()); end
    else begin
      n_tests++; if (got_idx[0] !== 8'd0) begin n_fail++; $display("FAIL single_idx: got %0d expected 0", got_idx[0]); end
      n_tests++; if (got_data[0] !== {32'hB, 32'hA}) begin n_fail++; $display("FAIL single_data: got %h expected %h", got_data[0], {32'hB, 32'hA}); end
    end
    n_tests++; if (first_fire_k != 11) begin n_fail++; $display("FAIL single_fire_cycle: got %0d expected 11", first_fire_k); end
    n_tests++; if (first_valid_k != 15) begin n_fail++; $display("FAIL single_valid_cycle: got %0d expected 15", first_valid_k); end
    n_tests++; if (ndone != 1 || done_k != 16) begin n_fail++; $display("FAIL single_done: got %0d@%0d expected 1@16", ndone, done_k); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    n_tests++; if (rd_addr.size() != 7 || rd_addr[0] !== 10'h010 || rd_addr[6] !== 10'h016) begin n_fail++;
      $display("FAIL single_reads: got %0d reads expected 7 at 010..016", rd_addr.size()); end
    net_fixed = 1'b0;
  endtask

  task automatic test_multi_stall();
    int bad_addr = 0;
    fill_ram('h3F8, 28);
    run_job(4, 'h3F8, 5, 1'b0, 1'b0, 0, 400);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL multi_timeout: job did not finish"); end
    n_tests++; if (got_idx.size() != 4) begin n_fail++; $display("FAIL multi_nres: got %0d expected 4", got_idx.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (got_idx[i] !== 8'(i) || got_data[i] !== exp_res(i)) begin n_fail++;
          $display("FAIL multi_res%0d: got %0d/%h expected %0d/%h", i, got_idx[i], got_data[i], i, exp_res(i)); end
      end
    end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL multi_stable: got %0d changes expected 0", unstable); end
    for (int j = 0; j < rd_addr.size(); j++) if (rd_addr[j] !== ADDR_W'('h3F8 + j)) bad_addr++;
    n_tests++; if (rd_addr.size() != 28 || bad_addr != 0) begin n_fail++;
      $display("FAIL multi_reads: got %0d reads %0d misplaced expected 28 0", rd_addr.size(), bad_addr); end
    n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL multi_done: got %0d expected 1", ndone); end
  endtask

  task automatic test_zero();
    run_job(0, 'h100, 0, 1'b0, 1'b0, 0, 20);
    n_tests++; if (ndone != 1 || done_k != 1) begin n_fail++; $display("FAIL zero_done: got %0d@%0d expected 1@1", ndone, done_k); end
    n_tests++; if (rd_addr.size() != 0 || nfire != 0) begin n_fail++;
      $display("FAIL zero_activity: got %0d reads %0d fires expected 0 0", rd_addr.size(), nfire); end
    n_tests++; if (busy !== 1'b0 || timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_abort();
    int late_done = 0;
    fill_ram('h040, 28);
    run_job(4, 'h040, 0, 1'b0, 1'b0, 3, 400);
    #1;
    n_tests++; if ({busy, done, ram_rd, net_in_rdy, res_valid} !== 5'b0 || net_reset !== 1'b1) begin n_fail++;
      $display("FAIL abort_flags: got %b/%b expected 00000/1", {busy, done, ram_rd, net_in_rdy, res_valid}, net_reset); end
    n_tests++; if (ram_addr !== '0 || net_data_in !== '0 || res_data !== '0 || res_idx !== '0) begin n_fail++;
      $display("FAIL abort_regs: got %h %h %h %h expected all 0", ram_addr, net_data_in, res_data, res_idx); end
    n_tests++; if (got_idx.size() != 2 || ndone != 0) begin n_fail++;
      $display("FAIL abort_progress: got %0d results %0d done expected 2 0", got_idx.size(), ndone); end
    repeat (3) begin @(negedge clk); if (done) late_done++; end
    n_tests++; if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", late_done); end
    reset = 1'b1;
    run_job(1, 'h040, 0, 1'b0, 1'b0, 0, 100);
    n_tests++; if (got_idx.size() != 1 || ndone != 1) begin n_fail++;
      $display("FAIL abort_rerun: got %0d results %0d done expected 1 1", got_idx.size(), ndone); end
    else begin
      n_tests++; if (got_idx[0] !== 8'd0 || got_data[0] !== exp_res(0)) begin n_fail++;
        $display("FAIL abort_rerun_res: got %0d/%h expected 0/%h", got_idx[0], got_data[0], exp_res(0)); end
    end
  endtask

  task automatic test_busy_ignore();
    fill_ram('h080, 14);
    run_job(2, 'h080, 0, 1'b1, 1'b1, 0, 200);
    n_tests++; if (got_idx.size() != 2 || nfire != 2 || ndone != 1) begin n_fail++;
      $display("FAIL ignore_counts: got %0d res %0d fires %0d done expected 2 2 1", got_idx.size(), nfire, ndone); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++; if (got_idx[i] !== 8'(i) || got_data[i] !== exp_res(i)) begin n_fail++;
          $display("FAIL ignore_res%0d: got %0d/%h expected %0d/%h", i, got_idx[i], got_data[i], i, exp_res(i)); end
      end
    end
    n_tests++; if (rd_addr.size() != 14 || rd_addr[0] !== 10'h080 || rd_addr[13] !== 10'h08D) begin n_fail++;
      $display("FAIL ignore_reads: got %0d reads expected 14 at 080..08D", rd_addr.size()); end
  endtask

`ifdef NET_TIMEOUT_EN
  task automatic test_timeout();
    fill_ram('h0C0, 21);
    skip_fire = 1;
    run_job(3, 'h0C0, 0, 1'b0, 1'b0, 0, 6000);
    skip_fire = -1;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err); end
    n_tests++; if (got_idx.size() != 2 || nfire != 3 || ndone != 1) begin n_fail++;
      $display("FAIL timeout_counts: got %0d res %0d fires %0d done expected 2 3 1", got_idx.size(), nfire, ndone); end
    else begin
      n_tests++; if (got_idx[0] !== 8'd0 || got_data[0] !== exp_res(0)) begin n_fail++;
        $display("FAIL timeout_res0: got %0d/%h expected 0/%h", got_idx[0], got_data[0], exp_res(0)); end
      n_tests++; if (got_idx[1] !== 8'd2 || got_data[1] !== exp_res(2)) begin n_fail++;
        $display("FAIL timeout_res2: got %0d/%h expected 2/%h", got_idx[1], got_data[1], exp_res(2)); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi_stall();
    test_zero();
    test_abort();
    test_busy_ignore();
`ifdef NET_TIMEOUT_EN
    test_timeout();
`else
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied: got %b expected 0", err); end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/net_seq.md
Name: net_seq

Overview:
- Sample scheduler for the MLP `net` datapath. Replaces the free-running input RAM hookup.
- Fetches each sample's N_IN words from a word-addressed input RAM into holding registers, then presents them to `net`.
- Clears `net` between samples and fires it with an `in_rdy` pulse.
- Waits for `net_rdy`, then hands the N_OUT result words to a downstream consumer over a valid/ready handshake.
- Sits between the input RAM, `net`, and the result sink inside `mlp`.

Parameters:
- WORD_W, 32, word width; equals `WordDataBus`.
- N_IN, 7, input words per sample.
- N_OUT, 2, output words per sample.
- ADDR_W, 10, input RAM address width.
- IDX_W, 8, sample-count width.
- CLR_CYC, 2, cycles `net_reset` is held high before each sample (≥1).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run; ignored unless IDLE.
- n_samples  in  IDX_W  samples in the run; sampled on `start`; 0 means an immediate done.
- base_addr  in  ADDR_W  RAM address of sample 0; sampled on `start`.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse at run end.
- ram_rd  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM read address.
- ram_data  in  WORD_W  RAM read data, valid exactly 1 cycle after `ram_rd`.
- net_reset  out  1  active-high clear to `net`.
- net_in_rdy  out  1  one-cycle fire pulse to `net`.
- net_data_in  out  N_IN*WORD_W  holding registers; word k occupies bits [k*WORD_W +: WORD_W].
- net_out  in  N_OUT*WORD_W  `net` result words.
- net_rdy  in  1  `net` result valid (level).
- res_valid  out  1  result available downstream.
- res_ready  in  1  downstream accept.
- res_data  out  N_OUT*WORD_W  captured result.
- res_idx  out  IDX_W  sample index of `res_data`.
- err  out  1  sticky timeout flag (NET_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state IDLE.
  - `busy`, `done`, `ram_rd`, `net_in_rdy`, `res_valid`, `err` all 0.
  - `net_reset` = 1; `net` is held cleared while idle.
  - `ram_addr`, `net_data_in`, `res_data`, `res_idx` all 0.
- Reset mid-run aborts immediately with no `done` pulse. Any pending result is dropped.
- States:
  - IDLE: `net_reset` = 1. On `start`: latch n_samples, base_addr; idx := 0; addr := base_addr.
    - n_samples = 0 → DONE.
    - Otherwise → LOAD.
  - LOAD: issue N_IN consecutive reads, `ram_rd` = 1 for N_IN cycles, addr incrementing by 1 each cycle.
    - Word k is captured into holding reg k one cycle after its read.
    - `net_reset` stays high throughout LOAD.
    - Leave LOAD after the last capture, i.e. N_IN+1 cycles after entry.
  - CLR: hold `net_reset` = 1 for CLR_CYC cycles, counting any overlap with LOAD tail as zero → FIRE.
  - FIRE: `net_reset` = 0; `net_in_rdy` = 1 for exactly one cycle → WAIT.
  - WAIT: when `net_rdy` = 1, capture `net_out` into `res_data`, set res_idx := idx, `res_valid` = 1 → OUT.
  - OUT: hold `res_data` and `res_idx` stable while `res_valid` && !`res_ready`.
    - On handshake: `res_valid` = 0 and idx := idx+1.
    - idx+1 == n_samples → DONE.
    - Otherwise → LOAD, with addr continuing sequentially (sample i starts at base_addr + i*N_IN).
  - DONE: `done` = 1 for one cycle; `net_reset` := 1 → IDLE.
- `start` while busy is ignored.
- `ram_addr` wraps modulo 2^ADDR_W with no error.
- `net_rdy` outside WAIT is ignored.
- `net_data_in` is held constant from the end of LOAD through WAIT.
- Best-case latency per sample, with `net_rdy` arriving L cycles after fire and `res_ready` tied high: N_IN+1 + CLR_CYC + 1 + L + 1 cycles.

Optional Feature:
- NET_TIMEOUT_EN defined:
  - A 16-bit watchdog counter runs in WAIT.
  - If 4096 cycles elapse without `net_rdy`: set `err` (sticky until reset), skip the sample without producing a result, increment idx, and continue as if in OUT after handshake.
  - The counter clears on WAIT entry.
- Undefined: no counter; WAIT waits indefinitely; `err` is constant 0.

Decomposition:
- Shared package/stddef additions:
  - State encoding defines: `NSEQ_IDLE`, `NSEQ_LOAD`, `NSEQ_CLR`, `NSEQ_FIRE`, `NSEQ_WAIT`, `NSEQ_OUT`, `NSEQ_DONE`.
  - `NSEQ_TIMEOUT` = 4096.
  - Reuse `WordDataBus`.
- Sub-module `net_seq_loader`: RAM read sequencer plus holding-register bank (read counter, capture pipeline). The FSM stays in `net_seq`.

Test Plan:
- Single sample: base_addr=0x010, n_samples=1, RAM[0x010..0x016]=1..7; `net` model returns {0xA,0xB} 3 cycles after fire; res_ready=1.
  → `net_data_in` words = 1..7; one `net_in_rdy` pulse; res_data={0xA,0xB}, res_idx=0; `done` pulse; `busy` low afterwards.
- Four samples with res_ready stalled 5 cycles per result.
  → res_idx 0,1,2,3 in order; `res_data` stable during each stall; reads cover base..base+27 exactly once.
- n_samples=0.
  → `done` pulses 1 cycle after `start`; no `ram_rd`, no `net_in_rdy`.
- Reset=0 asserted during WAIT of sample 2 of 4.
  → all outputs return to reset values asynchronously; no `done`; a fresh `start` runs normally from idx 0.
- `start` pulsed again while busy, plus spurious `net_rdy` during LOAD.
  → both ignored; sample count and results are unchanged.
- With NET_TIMEOUT_EN and `net_rdy` never asserted for sample 1 of 3.
  → `err` set after 4096 cycles; results produced for idx 0 and 2 only; `done` still pulses.
